sm_keypad_scan: RTL

SM_KEYPAD_SCAN -- requirements
Module: sm_keypad_scan

---
 rtl/sm_keypad_scan.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sm_keypad_scan.sv
// 4x4 matrix keypad scanner with frame-based debounce and a single-entry key holding register.
// Optional build macro SM_KEYPAD_7SEG_EN adds a registered hex 7-segment output key_seg.
`timescale 1ns/1ps

module sm_keypad_scan #(
   parameter int SCAN_DIV_W     = 9,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clkIn,
   input  logic       rst_n,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_overrun,
   output logic       key_down
`ifdef SM_KEYPAD_7SEG_EN
   ,
   output logic [6:0] key_seg
`endif
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_HELD     = 2'd2,
      S_RELEASE  = 2'd3
   } state_t;

   localparam logic [SCAN_DIV_W-1:0] DWELL_ONE = 1;
   localparam logic [3:0]            DEB_N     = 4'(DEBOUNCE_SCANS);

   logic [3:0]            row_sync_p0;
   logic [3:0]            row_sync_p1;
   logic [SCAN_DIV_W-1:0] dwell;
   logic [1:0]            col_idx;
   logic [11:0]           scan_img;
   logic [15:0]           frame_pressed;
   logic                  frame_boundary;
   logic                  frame_empty;
   logic [3:0]            frame_code;
   state_t                state;
   logic [3:0]            cnt;
   logic [3:0]            cnt_inc;
   logic [3:0]            cand;
   logic                  accept;

   function automatic logic [3:0] lowest_pressed(input logic [15:0] pressed);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (pressed[i]) idx = 4'(i);
      end
      return idx;
   endfunction

`ifdef SM_KEYPAD_7SEG_EN
   function automatic logic [6:0] hex7seg(input logic [3:0] v);
      logic [6:0] seg;
      case (v)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction
`endif

   assign col_n = ~(4'b0001 << col_idx);

   // Column 3 is never stored: at the frame boundary its rows are taken live from the synchronizer.
   assign frame_boundary = (&dwell) && (col_idx == 2'd3);
   assign frame_pressed  = ~{row_sync_p1, scan_img};
   assign frame_empty    = ~|frame_pressed;
   assign frame_code     = lowest_pressed(frame_pressed);
   assign cnt_inc        = cnt + 4'd1;
   assign accept         = frame_boundary && (state == S_DEBOUNCE) && !frame_empty &&
                           (frame_code == cand) && (cnt_inc == DEB_N);

   always_ff @(posedge clkIn) begin
      if (!rst_n) begin
         row_sync_p0 <= 4'b1111;
         row_sync_p1 <= 4'b1111;
         dwell       <= '0;
         col_idx     <= 2'd0;
         scan_img    <= '1;
      end else begin
         row_sync_p0 <= row_n;
         row_sync_p1 <= row_sync_p0;
         dwell       <= dwell + DWELL_ONE;
         if (&dwell) begin
            col_idx <= col_idx + 2'd1;
            case (col_idx)
               2'd0:    scan_img[3:0]  <= row_sync_p1;
               2'd1:    scan_img[7:4]  <= row_sync_p1;
               2'd2:    scan_img[11:8] <= row_sync_p1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clkIn) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= 4'd0;
         cand        <= 4'd0;
         key_code    <= 4'd0;
         key_valid   <= 1'b0;
         key_overrun <= 1'b0;
         key_down    <= 1'b0;
`ifdef SM_KEYPAD_7SEG_EN
         key_seg     <= 7'h3F;
`endif
      end else begin
         if (frame_boundary) begin
            case (state)
               S_IDLE: begin
                  if (!frame_empty) begin
                     state <= S_DEBOUNCE;
                     cand  <= frame_code;
                     cnt   <= 4'd1;
                  end
               end
               S_DEBOUNCE: begin
                  if (frame_empty) begin
                     state <= S_IDLE;
                     cnt   <= 4'd0;
                  end else if (frame_code != cand) begin
                     cand <= frame_code;
                     cnt  <= 4'd1;
                  end else if (cnt_inc == DEB_N) begin
                     state    <= S_HELD;
                     cnt      <= 4'd0;
                     key_down <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               S_HELD: begin
                  if (frame_empty) begin
                     state <= S_RELEASE;
                     cnt   <= 4'd1;
                  end
               end
               S_RELEASE: begin
                  if (!frame_empty) begin
                     state <= S_HELD;
                     cnt   <= 4'd0;
                  end else if (cnt_inc == DEB_N) begin
                     state    <= S_IDLE;
                     cnt      <= 4'd0;
                     key_down <= 1'b0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end

         // A same-cycle ack consumes the old key, so the newer one does not count as an overrun.
         if (accept) begin
            key_code  <= cand;
            key_valid <= 1'b1;
            if (key_valid && key_ack) begin
               key_overrun <= 1'b0;
            end else if (key_valid) begin
               key_overrun <= 1'b1;
            end
`ifdef SM_KEYPAD_7SEG_EN
            key_seg <= hex7seg(cand);
`endif
         end else if (key_ack && key_valid) begin
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
         end
      end
   end

endmodule
